// File: rtl/seq_control_unit.sv
// seq_control_unit: multi-cycle sequencer (IDLE/OPA/OPB/MEM/STORE) driving datapath strobes from a latched instruction.
// Define SEQ_CU_LS_TIMEOUT_EN to add an LS_TIMEOUT-cycle watchdog on the MEM state; ls_err is then meaningful.
module seq_control_unit #(
   parameter int DATA_W     = 16,
   parameter int LS_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [15:0]       instruction,
   input  logic              ls_done,
   output logic [3:0]        mux_sel,
   output logic [2:0]        sel,
   output logic              en_s,
   output logic              en_c,
   output logic              sel_reg_c,
   output logic [1:0]        en_ls,
   output logic [7:0]        en,
   output logic              en_inst,
   output logic [DATA_W-1:0] immediate,
   output logic              busy,
   output logic              done,
   output logic              ls_err
);
   typedef enum logic [2:0] {IDLE, OPA, OPB, MEM, STORE} state_t;
   state_t      state;
   logic [15:0] ir;
   logic        timed_out;
   logic        wr;
   wire  [1:0]  fmt     = ir[1:0];
   wire         ls_flag = ir[2];
   wire  [2:0]  op      = ir[4:2];
   wire  [2:0]  rb      = ir[12:10];
   wire  [2:0]  ra      = ir[15:13];
`ifdef SEQ_CU_LS_TIMEOUT_EN
   logic [7:0]  cnt;
   logic        err;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         ir    <= '0;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (run) begin
               ir    <= instruction;
               err   <= 1'b0;
               state <= (instruction[1:0] == 2'b10) ? STORE : OPA;
            end
            OPA: state <= OPB;
            OPB: begin
               cnt   <= '0;
               state <= (fmt == 2'b11) ? MEM : STORE;
            end
            // a completion arriving on the final watchdog cycle still counts as success
            MEM: if (ls_done) state <= STORE;
               else if (cnt == 8'(LS_TIMEOUT - 1)) begin
                  err   <= 1'b1;
                  state <= STORE;
               end else cnt <= cnt + 8'd1;
            STORE: begin
               err   <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   assign timed_out = err;
`else
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         ir    <= '0;
      end else begin
         case (state)
            IDLE: if (run) begin
               ir    <= instruction;
               state <= (instruction[1:0] == 2'b10) ? STORE : OPA;
            end
            OPA: state <= OPB;
            OPB: state <= (fmt == 2'b11) ? MEM : STORE;
            MEM: if (ls_done) state <= STORE;
            STORE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   assign timed_out = 1'b0;
`endif
   // only ALU/immediate results and completed loads write back
   assign wr        = !fmt[1] || (fmt == 2'b11 && !ls_flag && !timed_out);
   assign immediate = DATA_W'(ir[12:5]);
   always_comb begin
      mux_sel   = 4'd9;
      sel       = '0;
      en_s      = 1'b0;
      en_c      = 1'b0;
      sel_reg_c = 1'b0;
      en_ls     = 2'b00;
      en        = '0;
      en_inst   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      ls_err    = 1'b0;
      case (state)
         IDLE: en_inst = 1'b1;
         OPA: begin
            busy    = 1'b1;
            en_s    = 1'b1;
            mux_sel = {1'b0, ra};
         end
         OPB: begin
            busy    = 1'b1;
            sel     = op;
            mux_sel = (fmt == 2'b01) ? 4'd8 : {1'b0, rb};
            en_c    = !fmt[1];
         end
         MEM: begin
            busy      = 1'b1;
            en_ls     = ls_flag ? 2'b10 : 2'b01;
            sel_reg_c = 1'b1;
            en_c      = ls_done;
         end
         STORE: begin
            busy   = 1'b1;
            done   = 1'b1;
            en     = wr ? (8'd1 << ra) : 8'd0;
            ls_err = timed_out;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_seq_control_unit.sv
// tb_seq_control_unit: randomized sequencer bench; expected per-cycle outputs are built from the instruction's cycle plan.
module tb_seq_control_unit;
   localparam int DW = 32;
   localparam int TO = 4;
`ifdef SEQ_CU_LS_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   logic          clk = 1'b0;
   logic          reset, run, ls_done;
   logic [15:0]   instruction;
   logic [3:0]    mux_sel;
   logic [2:0]    sel;
   logic          en_s, en_c, sel_reg_c, en_inst, busy, done, ls_err;
   logic [1:0]    en_ls;
   logic [7:0]    en;
   logic [DW-1:0] immediate;
   int            checks = 0;
   int            errors = 0;
   logic [15:0]   last_ir = '0;

   seq_control_unit #(.DATA_W(DW), .LS_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .run(run), .instruction(instruction), .ls_done(ls_done),
      .mux_sel(mux_sel), .sel(sel), .en_s(en_s), .en_c(en_c), .sel_reg_c(sel_reg_c),
      .en_ls(en_ls), .en(en), .en_inst(en_inst), .immediate(immediate),
      .busy(busy), .done(done), .ls_err(ls_err)
   );

   always #5 clk = ~clk;

   wire [23:0] obs = {mux_sel, sel, en_s, en_c, sel_reg_c, en_ls, en, en_inst, busy, done, ls_err};

   function automatic logic [23:0] rec(input logic [3:0] m, input logic [2:0] s, input logic es, input logic ec,
                                       input logic src, input logic [1:0] ls, input logic [7:0] e,
                                       input logic ei, input logic b, input logic d, input logic le);
      return {m, s, es, ec, src, ls, e, ei, b, d, le};
   endfunction

   localparam logic [23:0] IDLE_R = {4'd9, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};

   // d: MEM cycle (1-based) on which ls_done pulses, 0 = never
   task automatic run_instr(input string name, input logic [15:0] ins, input int d, input bit hold_run);
      logic [23:0] exp_q[$];
      bit          ld_q[$];
      logic [1:0]  fmt;
      logic [2:0]  ra, rb, op;
      logic        ls, err, wr;
      int          n_mem, exp_lat, done_at;
      fmt = ins[1:0]; ls = ins[2]; op = ins[4:2]; rb = ins[12:10]; ra = ins[15:13];
      err = 1'b0; n_mem = 0; done_at = -1;
      exp_q.push_back(IDLE_R); ld_q.push_back(1'($urandom));
      if (fmt != 2'b10) begin
         exp_q.push_back(rec({1'b0, ra}, 3'd0, 1, 0, 0, 2'b00, 8'd0, 0, 1, 0, 0)); ld_q.push_back(1'($urandom));
         exp_q.push_back(rec(fmt == 2'b01 ? 4'd8 : {1'b0, rb}, op, 0, fmt <= 2'b01, 0, 2'b00, 8'd0, 0, 1, 0, 0));
         ld_q.push_back(1'($urandom));
      end
      if (fmt == 2'b11) begin
         for (int k = 1; k <= 300; k++) begin
            exp_q.push_back(rec(4'd9, 3'd0, 0, k == d, 1, ls ? 2'b10 : 2'b01, 8'd0, 0, 1, 0, 0));
            ld_q.push_back(k == d);
            n_mem = k;
            if (k == d || (TO_EN && k == TO)) begin
               err = (k != d);
               break;
            end
         end
      end
      wr = (fmt <= 2'b01) || (fmt == 2'b11 && !ls && !err);
      exp_q.push_back(rec(4'd9, 3'd0, 0, 0, 0, 2'b00, wr ? (8'd1 << ra) : 8'd0, 0, 1, 1, err));
      ld_q.push_back(1'($urandom));
      exp_lat = (fmt == 2'b10) ? 2 : (fmt != 2'b11) ? 4 : 4 + n_mem;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         ls_done = ld_q[i];
         if (i == 0) begin
            instruction = ins;
            run = 1'b1;
         end else begin
            instruction = 16'($urandom);
            run = hold_run ? 1'b1 : 1'($urandom);
         end
         #1;
         checks++;
         if (obs !== exp_q[i]) begin
            errors++;
            $display("FAIL %s ins=%h cyc=%0d outputs=%h expected=%h", name, ins, i, obs, exp_q[i]);
         end
         checks++;
         if (immediate !== DW'(i == 0 ? last_ir[12:5] : ins[12:5])) begin
            errors++;
            $display("FAIL %s_imm ins=%h cyc=%0d got=%h expected=%h", name, ins, i, immediate,
                     DW'(i == 0 ? last_ir[12:5] : ins[12:5]));
         end
         if (done && done_at < 0) done_at = i + 1;
      end
      last_ir = ins;
      if (!hold_run) run = 1'b0;
      ls_done = 1'b0;
      checks++;
      if (done_at != exp_lat) begin
         errors++;
         $display("FAIL %s_latency ins=%h got=%0d expected=%0d", name, ins, done_at, exp_lat);
      end
   endtask

   function automatic logic [15:0] rnd_ins(input logic [1:0] fmt);
      logic [15:0] v;
      v = 16'($urandom);
      v[1:0] = fmt;
      return v;
   endfunction

   task automatic check_idle(input string name, input int cycles, input bit in_reset);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         instruction = 16'($urandom);
         ls_done = 1'($urandom);
         run = in_reset ? 1'($urandom) : 1'b0;
         #1;
         checks++;
         if (obs !== IDLE_R || immediate !== DW'(last_ir[12:5])) begin
            errors++;
            $display("FAIL %s cyc=%0d outputs=%h imm=%h expected=%h imm=%h", name, i, obs, immediate,
                     IDLE_R, DW'(last_ir[12:5]));
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; run = 1'b1; ls_done = 1'b1; instruction = 16'hFFFF;
      last_ir = '0;
      check_idle("reset", 4, 1'b1);
      @(posedge clk); #2;
      reset = 1'b1; run = 1'b0; ls_done = 1'b0;
      check_idle("idle_hold", 3, 1'b0);
   endtask

   task automatic test_alu();
      run_instr("alu_directed", {3'd3, 3'd5, 5'd0, 3'd2, 2'b00}, 0, 1'b0);
      for (int i = 0; i < 6; i++) run_instr("alu", rnd_ins(2'b00), 0, 1'b0);
   endtask

   task automatic test_imm();
      run_instr("imm_directed", {3'd6, 8'hA5, 3'd1, 2'b01}, 0, 1'b0);
      for (int i = 0; i < 6; i++) run_instr("imm", rnd_ins(2'b01), 0, 1'b0);
   endtask

   task automatic test_mem();
      run_instr("mem_directed", {3'd2, 8'h3C, 3'b000, 2'b11}, 3, 1'b0);
      run_instr("mem_first", rnd_ins(2'b11), 1, 1'b0);
      for (int i = 0; i < 10; i++) run_instr("mem", rnd_ins(2'b11), TO_EN ? $urandom_range(0, 6) : $urandom_range(1, 6), 1'b0);
   endtask

   task automatic test_timeout();
      if (TO_EN) begin
         run_instr("timeout_store", {3'd4, 8'h11, 3'b001, 2'b11}, 0, 1'b0);
         run_instr("timeout_load", {3'd1, 8'h22, 3'b000, 2'b11}, 0, 1'b0);
         run_instr("timeout_edge", rnd_ins(2'b11), TO, 1'b0);
      end
   endtask

   task automatic test_nop();
      for (int i = 0; i < 4; i++) run_instr("nop", rnd_ins(2'b10), 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_instr("b2b_nop", rnd_ins(2'b10), 0, 1'b1);
      run_instr("b2b_nop2", rnd_ins(2'b10), 0, 1'b1);
      for (int i = 0; i < 8; i++) run_instr("b2b", rnd_ins(2'($urandom)), $urandom_range(1, 3), 1'b1);
      run = 1'b0;
      check_idle("b2b_settle", 2, 1'b0);
   endtask

   task automatic test_reset_mid_mem();
      logic [15:0] ins;
      ins = rnd_ins(2'b11);
      @(negedge clk);
      instruction = ins; run = 1'b1; ls_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         run = 1'b0; ls_done = 1'b0;
      end
      #1;
      checks++;
      if (sel_reg_c !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_mem_entry sel_reg_c=%b busy=%b expected 1 1", sel_reg_c, busy);
      end
      #1; reset = 1'b0; #1;
      last_ir = '0;
      checks++;
      if (obs !== IDLE_R || immediate !== '0) begin
         errors++;
         $display("FAIL async_reset outputs=%h imm=%h expected=%h imm=0", obs, immediate, IDLE_R);
      end
      check_idle("reset_hold", 3, 1'b1);
      @(posedge clk); #2;
      reset = 1'b1; run = 1'b0;
      run_instr("after_reset", rnd_ins(2'b00), 0, 1'b0);
      run_instr("after_reset_mem", rnd_ins(2'b11), 2, 1'b0);
   endtask

   initial begin
      test_reset();
      test_alu();
      test_imm();
      test_mem();
      test_timeout();
      test_nop();
      test_back_to_back();
      test_reset_mid_mem();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
